membus_arbiter: RTL

Shares one single-outstanding memory bus between the instruction-fetch port (driven by the fetch/jump controller) and the load/store data port. It grants one requester per issue slot, forwards the winning command to the shared bus, tracks the owner of the outstanding transaction and routes the response back to that owner only. Data requests have priority, and an aging counter prevents fetch starvation.

---
 rtl/membus_arbiter_pkg.sv | 15 +
 rtl/membus_pick.sv | 24 ++
 rtl/membus_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/membus_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter: owner-state encoding,
// default bus widths and the data-streak counter width.
package membus_arbiter_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned BUS_WID_DEF = 64;
  localparam int unsigned STREAK_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/membus_pick.sv
// Combinational requester picker: data has priority unless the data streak
// has reached its limit while fetch is also waiting.
module membus_pick (
  input  logic slot,
  input  logic imem_req,
  input  logic dmem_req,
  input  logic streak_full,
  output logic gnt_i,
  output logic gnt_d
);

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (slot) begin
      if (dmem_req && !(imem_req && streak_full)) begin
        gnt_d = 1'b1;
      end else if (imem_req) begin
        gnt_i = 1'b1;
      end
    end
  end

endmodule

// File: rtl/membus_arbiter.sv
// Shares one single-outstanding memory bus between the fetch and data ports,
// tracking the owner of the outstanding transaction for response routing.
module membus_arbiter
  import membus_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned BUS_WID      = BUS_WID_DEF,
  parameter int unsigned D_STREAK_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_req,
  input  logic [XLEN-1:0]      imem_addr,
  output logic                 imem_gnt,
  output logic [BUS_WID-1:0]   imem_rdata,
  output logic                 imem_resp,
  output logic                 imem_err,
  input  logic                 dmem_req,
  input  logic                 dmem_we,
  input  logic [XLEN-1:0]      dmem_addr,
  input  logic [BUS_WID-1:0]   dmem_wdata,
  input  logic [BUS_WID/8-1:0] dmem_be,
  output logic                 dmem_gnt,
  output logic [BUS_WID-1:0]   dmem_rdata,
  output logic                 dmem_resp,
  output logic                 dmem_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [BUS_WID-1:0]   mem_wdata,
  output logic [BUS_WID/8-1:0] mem_be,
  input  logic [BUS_WID-1:0]   mem_rdata,
  input  logic                 mem_resp,
  input  logic                 mem_err
);

  arb_state_e            state_q, state_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  slot;
  logic                  streak_full;
  logic                  gnt_i, gnt_d;

  // Qualifying the slot with reset keeps every grant-derived output at zero
  // while reset is held, even though the state already reads IDLE.
  assign slot        = rst & ((state_q == IDLE) | mem_resp);
  assign streak_full = (streak_q == STREAK_W'(D_STREAK_MAX));

  membus_pick u_pick (
    .slot       (slot),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .streak_full(streak_full),
    .gnt_i      (gnt_i),
    .gnt_d      (gnt_d)
  );

  assign imem_gnt = gnt_i;
  assign dmem_gnt = gnt_d;
  assign mem_req  = gnt_i | gnt_d;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (gnt_d) begin
      mem_we    = dmem_we;
      mem_addr  = dmem_addr;
      mem_wdata = dmem_wdata;
      mem_be    = dmem_be;
    end else if (gnt_i) begin
      mem_addr  = imem_addr;
      mem_be    = '1;
    end
  end

  assign imem_resp  = rst & mem_resp & (state_q == BUSY_I);
  assign dmem_resp  = rst & mem_resp & (state_q == BUSY_D);
  assign imem_rdata = rst ? mem_rdata : '0;
  assign dmem_rdata = rst ? mem_rdata : '0;
  assign imem_err   = rst & mem_err;
  assign dmem_err   = rst & mem_err;

  always_comb begin
    state_d = state_q;
    if (gnt_i) begin
      state_d = BUSY_I;
    end else if (gnt_d) begin
      state_d = BUSY_D;
    end else if (mem_resp) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (gnt_i || !imem_req) begin
      streak_d = '0;
    end else if (gnt_d && !streak_full) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

endmodule
